// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The sequencer takes the slave side; the board-level logic or a bench takes the master side.
interface pll_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             relock_req;
    logic             pll_reset;
    logic             sys_rst;
    logic             pll_fault;
    logic [1:0]       state;
    logic [3:0]       retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        output pll_lock,
        output relock_req,
        input  pll_reset,
        input  sys_rst,
        input  pll_fault,
        input  state,
        input  retry_cnt,
        input  loss_cnt
    );

    modport slave (
        input  pll_lock,
        input  relock_req,
        output pll_reset,
        output sys_rst,
        output pll_fault,
        output state,
        output retry_cnt,
        output loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases the system reset.
// It retries on lock timeout, re-sequences on lock loss and latches a fault after too many retries.
module pll_reset_sequencer #(
    parameter int RST_CYC      = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 8
) (
    input  logic                   clk_100m,
    input  logic                   reset_n,
    pll_reset_sequencer_if.slave   bus
);

    localparam int HW = $clog2(RST_CYC);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [HW-1:0]    HOLD_LAST    = HW'(RST_CYC - 1);
    localparam logic [HW-1:0]    HOLD_ONE     = HW'(1);
    localparam logic [SW-1:0]    STABLE_DONE  = SW'(LOCK_STABLE);
    localparam logic [SW-1:0]    STABLE_ONE   = SW'(1);
    localparam logic [TW-1:0]    TIMEOUT_DONE = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0]    TIMEOUT_ONE  = TW'(1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);
    localparam logic [3:0]       RETRY_ONE    = 4'd1;
    localparam logic [CNT_W-1:0] LOSS_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_RUN       = 2'b10,
        ST_FAIL      = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [TW-1:0]    timeout_q, timeout_d;
    logic [3:0]       retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             sync1_q, sync1_d;
    logic             lock_s_q, lock_s_d;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_rst_q, sys_rst_d;
    logic             pll_fault_q, pll_fault_d;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stable_d    = stable_q;
        timeout_d   = timeout_q;
        retry_d     = retry_q;
        loss_d      = loss_q;
        sync1_d     = bus.pll_lock;
        lock_s_d    = sync1_q;

        unique case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    hold_d    = '0;
                    stable_d  = '0;
                    timeout_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (!lock_s_q) begin
                    stable_d = '0;
                end else if (stable_q != STABLE_DONE) begin
                    stable_d = stable_q + STABLE_ONE;
                end
                if (timeout_q != TIMEOUT_DONE) begin
                    timeout_d = timeout_q + TIMEOUT_ONE;
                end
                // A lock that becomes stable on the timeout cycle still counts as success.
                if (stable_d == STABLE_DONE) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else if (timeout_d == TIMEOUT_DONE) begin
                    retry_d   = (retry_q == 4'hF) ? retry_q : retry_q + RETRY_ONE;
                    state_d   = (retry_d == RETRY_MAX) ? ST_FAIL : ST_HOLD;
                    hold_d    = '0;
                    stable_d  = '0;
                    timeout_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d   = ST_HOLD;
                    loss_d    = (loss_q == '1) ? loss_q : loss_q + LOSS_ONE;
                    hold_d    = '0;
                    stable_d  = '0;
                    timeout_d = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (bus.relock_req) begin
            state_d   = ST_HOLD;
            retry_d   = '0;
            loss_d    = loss_q;
            hold_d    = '0;
            stable_d  = '0;
            timeout_d = '0;
        end

        // sys_rst follows the current state, so it lags RUN entry and exit by one cycle.
        pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
        sys_rst_d   = (state_q != ST_RUN);
        pll_fault_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            hold_q      <= '0;
            stable_q    <= '0;
            timeout_q   <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stable_q    <= stable_d;
            timeout_q   <= timeout_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            pll_fault_q <= pll_fault_d;
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.pll_fault = pll_fault_q;
    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Expected values are hand-derived cycle counts from reset release or stimulus edges.
module tb_pll_reset_sequencer;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_FLT  = 2'b11;

    logic clk_100m = 1'b0;
    logic reset_n  = 1'b0;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    pll_reset_sequencer_if #(.CNT_W(8)) bus ();

    pll_reset_sequencer #(
        .RST_CYC      (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (50),
        .MAX_RETRY    (3),
        .CNT_W        (8)
    ) dut (
        .clk_100m (clk_100m),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d expected %0d", bus.state, S_HOLD); end
        n_compared++; if (bus.pll_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_pll_reset: got %0d expected 1", bus.pll_reset); end
        n_compared++; if (bus.sys_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_sys_rst: got %0d expected 1", bus.sys_rst); end
        n_compared++; if (bus.pll_fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_pll_fault: got %0d expected 0", bus.pll_fault); end
        n_compared++; if (bus.retry_cnt !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_retry: got %0d expected 0", bus.retry_cnt); end
        n_compared++; if (bus.loss_cnt !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_loss: got %0d expected 0", bus.loss_cnt); end
    endtask

    task automatic test_nominal();
        int n;
        reset_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.pll_reset === 1'b1 && n < 20);
        n_compared++; if (n !== 4) begin n_mismatched++; $display("[TB] FAIL nominal_pll_reset_width: got %0d expected 4", n); end
        n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL nominal_wait_state: got %0d expected %0d", bus.state, S_WAIT); end
        repeat (6) tick();
        bus.pll_lock = 1'b1;
        repeat (9) tick();
        n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL nominal_not_yet_run: got %0d expected %0d", bus.state, S_WAIT); end
        tick();
        n_compared++; if (bus.state !== S_RUN) begin n_mismatched++; $display("[TB] FAIL nominal_run_state: got %0d expected %0d", bus.state, S_RUN); end
        n_compared++; if (bus.sys_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL nominal_sys_rst_lag: got %0d expected 1", bus.sys_rst); end
        tick();
        n_compared++; if (bus.sys_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nominal_sys_rst_release: got %0d expected 0", bus.sys_rst); end
        n_compared++; if (bus.pll_reset !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nominal_pll_reset_low: got %0d expected 0", bus.pll_reset); end
    endtask

    task automatic test_chatter();
        logic reached_run;
        reached_run = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL chatter_relock_state: got %0d expected %0d", bus.state, S_HOLD); end
        for (int i = 1; i <= 54; i++) begin
            if (i % 5 == 0) bus.pll_lock = ~bus.pll_lock;
            tick();
            if (bus.state === S_RUN) reached_run = 1'b1;
            if (i == 53) begin
                n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL chatter_before_timeout: got %0d expected %0d", bus.state, S_WAIT); end
            end
        end
        n_compared++; if (reached_run !== 1'b0) begin n_mismatched++; $display("[TB] FAIL chatter_never_run: got %0d expected 0", reached_run); end
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL chatter_timeout_state: got %0d expected %0d", bus.state, S_HOLD); end
        n_compared++; if (bus.retry_cnt !== 4'd1) begin n_mismatched++; $display("[TB] FAIL chatter_retry: got %0d expected 1", bus.retry_cnt); end
        n_compared++; if (bus.loss_cnt !== 8'd0) begin n_mismatched++; $display("[TB] FAIL chatter_loss_untouched: got %0d expected 0", bus.loss_cnt); end
    endtask

    task automatic test_timeout_fault();
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n_compared++; if (bus.retry_cnt !== 4'd0) begin n_mismatched++; $display("[TB] FAIL fault_retry_cleared: got %0d expected 0", bus.retry_cnt); end
        for (int i = 1; i <= 162; i++) begin
            tick();
            if (i == 54) begin
                n_compared++; if (bus.retry_cnt !== 4'd1) begin n_mismatched++; $display("[TB] FAIL fault_retry_first: got %0d expected 1", bus.retry_cnt); end
            end
            if (i == 108) begin
                n_compared++; if (bus.retry_cnt !== 4'd2) begin n_mismatched++; $display("[TB] FAIL fault_retry_second: got %0d expected 2", bus.retry_cnt); end
            end
            if (i == 161) begin
                n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL fault_last_wait: got %0d expected %0d", bus.state, S_WAIT); end
            end
        end
        n_compared++; if (bus.state !== S_FLT) begin n_mismatched++; $display("[TB] FAIL fault_state: got %0d expected %0d", bus.state, S_FLT); end
        n_compared++; if (bus.pll_fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fault_flag: got %0d expected 1", bus.pll_fault); end
        n_compared++; if (bus.pll_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fault_pll_reset: got %0d expected 1", bus.pll_reset); end
        n_compared++; if (bus.retry_cnt !== 4'd3) begin n_mismatched++; $display("[TB] FAIL fault_retry_final: got %0d expected 3", bus.retry_cnt); end
        repeat (10) tick();
        n_compared++; if (bus.state !== S_FLT) begin n_mismatched++; $display("[TB] FAIL fault_sticky: got %0d expected %0d", bus.state, S_FLT); end
        bus.pll_lock   = 1'b1;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n_compared++; if (bus.pll_fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fault_exit_flag: got %0d expected 0", bus.pll_fault); end
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL fault_exit_state: got %0d expected %0d", bus.state, S_HOLD); end
        repeat (12) tick();
        n_compared++; if (bus.state !== S_RUN) begin n_mismatched++; $display("[TB] FAIL fault_relock_run: got %0d expected %0d", bus.state, S_RUN); end
        n_compared++; if (bus.retry_cnt !== 4'd0) begin n_mismatched++; $display("[TB] FAIL fault_relock_retry: got %0d expected 0", bus.retry_cnt); end
        tick();
        n_compared++; if (bus.sys_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fault_relock_sys_rst: got %0d expected 0", bus.sys_rst); end
    endtask

    task automatic test_lock_loss();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        repeat (2) tick();
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL loss_to_hold: got %0d expected %0d", bus.state, S_HOLD); end
        n_compared++; if (bus.loss_cnt !== 8'd1) begin n_mismatched++; $display("[TB] FAIL loss_count_one: got %0d expected 1", bus.loss_cnt); end
        tick();
        n_compared++; if (bus.sys_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL loss_sys_rst: got %0d expected 1", bus.sys_rst); end
        repeat (11) tick();
        n_compared++; if (bus.state !== S_RUN) begin n_mismatched++; $display("[TB] FAIL loss_resequence_run: got %0d expected %0d", bus.state, S_RUN); end
        tick();
        n_compared++; if (bus.sys_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loss_resequence_sys_rst: got %0d expected 0", bus.sys_rst); end
        for (int k = 2; k <= 300; k++) begin
            bus.pll_lock = 1'b0;
            tick();
            bus.pll_lock = 1'b1;
            repeat (15) tick();
            if (k == 100) begin
                n_compared++; if (bus.loss_cnt !== 8'd100) begin n_mismatched++; $display("[TB] FAIL loss_count_100: got %0d expected 100", bus.loss_cnt); end
            end
        end
        n_compared++; if (bus.loss_cnt !== 8'd255) begin n_mismatched++; $display("[TB] FAIL loss_saturate: got %0d expected 255", bus.loss_cnt); end
        n_compared++; if (bus.state !== S_RUN) begin n_mismatched++; $display("[TB] FAIL loss_final_run: got %0d expected %0d", bus.state, S_RUN); end
    endtask

    task automatic test_mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL midrst_run_state: got %0d expected %0d", bus.state, S_HOLD); end
        n_compared++; if (bus.pll_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_run_pll_reset: got %0d expected 1", bus.pll_reset); end
        n_compared++; if (bus.sys_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_run_sys_rst: got %0d expected 1", bus.sys_rst); end
        n_compared++; if (bus.loss_cnt !== 8'd0) begin n_mismatched++; $display("[TB] FAIL midrst_run_loss: got %0d expected 0", bus.loss_cnt); end
        reset_n = 1'b1;
        repeat (6) tick();
        n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL midrst_reach_wait: got %0d expected %0d", bus.state, S_WAIT); end
        #2;
        reset_n = 1'b0;
        #1;
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL midrst_wait_state: got %0d expected %0d", bus.state, S_HOLD); end
        n_compared++; if (bus.pll_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_wait_pll_reset: got %0d expected 1", bus.pll_reset); end
        bus.pll_lock = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_priority();
        reset_n = 1'b1;
        repeat (53) tick();
        n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL prio_pre_state: got %0d expected %0d", bus.state, S_WAIT); end
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL prio_state: got %0d expected %0d", bus.state, S_HOLD); end
        n_compared++; if (bus.retry_cnt !== 4'd0) begin n_mismatched++; $display("[TB] FAIL prio_retry: got %0d expected 0", bus.retry_cnt); end
        repeat (3) tick();
        n_compared++; if (bus.state !== S_HOLD) begin n_mismatched++; $display("[TB] FAIL prio_hold_len: got %0d expected %0d", bus.state, S_HOLD); end
        tick();
        n_compared++; if (bus.state !== S_WAIT) begin n_mismatched++; $display("[TB] FAIL prio_hold_exit: got %0d expected %0d", bus.state, S_WAIT); end
    endtask

    initial begin
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_nominal();
        test_chatter();
        test_timeout_fault();
        test_lock_loss();
        test_mid_reset();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
